fifo_pixel_reader: RTL and testbench



---
 rtl/fifo_pixel_reader.sv | 185 ++++++++++++++++++
 tb/tb_fifo_pixel_reader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pixel_reader.sv
// Purpose: pops pixels from a show-ahead FIFO and presents them as a tagged valid/ready stream; drops and resyncs on FIFO overflow.
// Latency: one cycle from FIFO pop to pix_valid/pix_data; one pixel per cycle with pix_ready high.
// Backpressure: pix_valid && !pix_ready blocks the pop and freezes every output; a pop may share a cycle with a beat.
module fifo_pixel_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_start_in,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_empty_in,
    input  logic                  fifo_overflow_in,
    output logic                  fifo_rd_ack_out,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [COL_W-1:0]      pix_col,
    output logic [ROW_W-1:0]      pix_row,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  pix_eof,
    output logic                  frame_done,
    output logic                  err_overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    state_t                  state_q;
    logic                    stop_pending_q;
    logic [COL_W-1:0]        nxt_col_q;
    logic [ROW_W-1:0]        nxt_row_q;
    logic [COL_W-1:0]        nxt_col_d;
    logic [ROW_W-1:0]        nxt_row_d;
    logic [DATA_WIDTH-1:0]   pix_data_q;
    logic                    pix_valid_q;
    logic [COL_W-1:0]        pix_col_q;
    logic [ROW_W-1:0]        pix_row_q;
    logic                    pix_sof_q;
    logic                    pix_eol_q;
    logic                    pix_eof_q;
    logic                    frame_done_q;
    logic                    err_overflow_q;

    logic beat;
    logic pop;
    logic at_last_col;
    logic at_last_row;

    assign beat        = pix_valid_q && pix_ready;
    assign at_last_col = (nxt_col_q == LAST_COL);
    assign at_last_row = (nxt_row_q == LAST_ROW);

    // Pop strobe: DISCARD eats everything; RUN pops when the holding register is free or emptying this cycle.
    // Reset and overflow both block the pop so the FIFO is never read while its state is in doubt.
    assign pop = !reset && !fifo_empty_in && !fifo_overflow_in &&
                 ((state_q == S_DISCARD) ||
                  ((state_q == S_RUN) && !stop_pending_q && (!pix_valid_q || pix_ready)));

    assign fifo_rd_ack_out = pop;

    // Raster position of the pixel after the one at nxt_col_q/nxt_row_q.
    always_comb begin
        nxt_col_d = nxt_col_q + COL_W'(1);
        nxt_row_d = nxt_row_q;
        if (at_last_col) begin
            nxt_col_d = '0;
            nxt_row_d = at_last_row ? '0 : (nxt_row_q + ROW_W'(1));
        end
    end

    // Controller FSM with the output holding register; overflow outranks every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            stop_pending_q <= 1'b0;
            nxt_col_q      <= '0;
            nxt_row_q      <= '0;
            pix_data_q     <= '0;
            pix_valid_q    <= 1'b0;
            pix_col_q      <= '0;
            pix_row_q      <= '0;
            pix_sof_q      <= 1'b0;
            pix_eol_q      <= 1'b0;
            pix_eof_q      <= 1'b0;
            frame_done_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (fifo_overflow_in) begin
                state_q        <= S_DISCARD;
                stop_pending_q <= 1'b0;
                nxt_col_q      <= '0;
                nxt_row_q      <= '0;
                pix_valid_q    <= 1'b0;
                pix_sof_q      <= 1'b0;
                pix_eol_q      <= 1'b0;
                pix_eof_q      <= 1'b0;
                err_overflow_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (beat) begin
                            pix_valid_q <= 1'b0;
                            pix_sof_q   <= 1'b0;
                            pix_eol_q   <= 1'b0;
                            pix_eof_q   <= 1'b0;
                        end
                        if (enable) begin
                            state_q   <= S_RUN;
                            nxt_col_q <= '0;
                            nxt_row_q <= '0;
                        end
                    end
                    S_RUN: begin
                        // Frame boundary: the only place enable is honoured.
                        if (beat && pix_eof_q) begin
                            frame_done_q   <= 1'b1;
                            stop_pending_q <= 1'b0;
                            if (stop_pending_q) begin
                                state_q <= S_IDLE;
                            end
                        end
                        if (pop) begin
                            pix_data_q  <= fifo_data_in;
                            pix_valid_q <= 1'b1;
                            pix_col_q   <= nxt_col_q;
                            pix_row_q   <= nxt_row_q;
                            pix_sof_q   <= (nxt_col_q == '0) && (nxt_row_q == '0);
                            pix_eol_q   <= at_last_col;
                            pix_eof_q   <= at_last_col && at_last_row;
                            nxt_col_q   <= nxt_col_d;
                            nxt_row_q   <= nxt_row_d;
                            if (at_last_col && at_last_row && !enable) begin
                                stop_pending_q <= 1'b1;
                            end
                        end else if (beat) begin
                            pix_valid_q <= 1'b0;
                            pix_sof_q   <= 1'b0;
                            pix_eol_q   <= 1'b0;
                            pix_eof_q   <= 1'b0;
                        end
                    end
                    S_DISCARD: begin
                        pix_valid_q <= 1'b0;
                        pix_sof_q   <= 1'b0;
                        pix_eol_q   <= 1'b0;
                        pix_eof_q   <= 1'b0;
                        // Upstream vsync with an empty FIFO is a clean frame boundary to realign on.
                        if (frame_start_in && fifo_empty_in) begin
                            state_q   <= enable ? S_RUN : S_IDLE;
                            nxt_col_q <= '0;
                            nxt_row_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign pix_data     = pix_data_q;
    assign pix_valid    = pix_valid_q;
    assign pix_col      = pix_col_q;
    assign pix_row      = pix_row_q;
    assign pix_sof      = pix_sof_q;
    assign pix_eol      = pix_eol_q;
    assign pix_eof      = pix_eof_q;
    assign frame_done   = frame_done_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Purpose: directed bench for fifo_pixel_reader on a 4x2 image with a queue-based show-ahead FIFO model and a scoreboard.
// Latency: expected pixels are queued when written to the FIFO model and compared on each handshake.
// Backpressure: pix_ready is driven per step to exercise stalls.
module tb_fifo_pixel_reader;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CW = 3;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          frame_start_in;
    logic [DW-1:0] fifo_data_in;
    logic          fifo_empty_in;
    logic          fifo_overflow_in;
    logic          fifo_rd_ack_out;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic [CW-1:0] pix_col;
    logic [RW-1:0] pix_row;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;
    logic          frame_done;
    logic          err_overflow;

    fifo_pixel_reader #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .COL_W      (CW),
        .ROW_W      (RW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .frame_start_in   (frame_start_in),
        .fifo_data_in     (fifo_data_in),
        .fifo_empty_in    (fifo_empty_in),
        .fifo_overflow_in (fifo_overflow_in),
        .fifo_rd_ack_out  (fifo_rd_ack_out),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_col          (pix_col),
        .pix_row          (pix_row),
        .pix_sof          (pix_sof),
        .pix_eol          (pix_eol),
        .pix_eof          (pix_eof),
        .frame_done       (frame_done),
        .err_overflow     (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          sof;
        logic          eol;
        logic          eof;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] fifo_q[$];
    int            n_assert   = 0;
    int            n_fail     = 0;
    int            beats_seen = 0;
    int            cyc        = 0;
    int            tb_col     = 0;
    int            tb_row     = 0;
    int            span;
    logic          discarding = 1'b0;
    logic          fd_exp     = 1'b0;
    logic          prev_stall = 1'b0;
    logic          last_ack   = 1'b0;
    logic [DW-1:0] prev_data;
    logic [CW-1:0] prev_col;
    logic [RW-1:0] prev_row;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Write a word into the FIFO model; outside DISCARD it also becomes an expected pixel.
    task automatic push_px(input logic [DW-1:0] d);
        exp_t e;
        fifo_q.push_back(d);
        if (!discarding) begin
            e.data = d;
            e.col  = CW'(tb_col);
            e.row  = RW'(tb_row);
            e.sof  = (tb_col == 0) && (tb_row == 0);
            e.eol  = (tb_col == W - 1);
            e.eof  = (tb_col == W - 1) && (tb_row == H - 1);
            exp_q.push_back(e);
            if (tb_col == W - 1) begin
                tb_col = 0;
                tb_row = (tb_row == H - 1) ? 0 : tb_row + 1;
            end else begin
                tb_col++;
            end
        end
    endtask

    // One clock: drive FIFO model, sample mid-cycle, check, then pop the model on an acked edge.
    task automatic step();
        logic ack_s;
        logic fd_next;
        exp_t e;
        fifo_empty_in = (fifo_q.size() == 0);
        fifo_data_in  = fifo_empty_in ? '0 : fifo_q[0];
        #4;
        ack_s   = fifo_rd_ack_out;
        fd_next = 1'b0;
        if (!reset) begin
            check("frame_done", 32'(frame_done), 32'(fd_exp));
            if (!pix_valid) check("flags_when_invalid", 32'({pix_sof, pix_eol, pix_eof}), 32'(0));
            if (pix_valid && !pix_ready) check("stall_no_pop", 32'(ack_s), 32'(0));
            if (prev_stall && pix_valid) begin
                check("hold_data", 32'(pix_data), 32'(prev_data));
                check("hold_pos", 32'({pix_col, pix_row}), 32'({prev_col, prev_row}));
            end
            if (pix_valid && pix_ready && !fifo_overflow_in) begin
                n_assert++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL spurious_beat: observed beat with data 0x%0h, expected no beat", pix_data);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(pix_data), 32'(e.data));
                    check("beat_col", 32'(pix_col), 32'(e.col));
                    check("beat_row", 32'(pix_row), 32'(e.row));
                    check("beat_flags", 32'({pix_sof, pix_eol, pix_eof}), 32'({e.sof, e.eol, e.eof}));
                    fd_next = e.eof;
                end
                beats_seen++;
            end
        end
        prev_stall = !reset && pix_valid && !pix_ready;
        prev_data  = pix_data;
        prev_col   = pix_col;
        prev_row   = pix_row;
        last_ack   = ack_s;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (ack_s && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
        fd_exp = fd_next;
    endtask

    task automatic run_beats(input int n, output int span_o);
        int target;
        int first;
        int last;
        int b;
        target = beats_seen + n;
        first  = -1;
        last   = -1;
        for (int i = 0; i < 100 && beats_seen < target; i++) begin
            b = beats_seen;
            step();
            if (beats_seen != b) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        check("beat_count", 32'(beats_seen), 32'(target));
        span_o = last - first;
    endtask

    task automatic wait_data(input logic [DW-1:0] val);
        for (int i = 0; i < 40 && !(pix_valid && pix_data == val); i++) step();
        check("wait_data", 32'({pix_valid, pix_data}), 32'({1'b1, val}));
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({pix_valid, pix_data, pix_col, pix_row, pix_sof, pix_eol, pix_eof,
                        frame_done, err_overflow, fifo_rd_ack_out}), 32'(0));
    endtask

    initial begin
        logic [DW-1:0] tmp[$];
        reset            = 1'b1;
        enable           = 1'b0;
        frame_start_in   = 1'b0;
        fifo_overflow_in = 1'b0;
        pix_ready        = 1'b1;
        fifo_data_in     = '0;
        fifo_empty_in    = 1'b1;

        // Reset values
        step();
        step();
        check_all_zero("reset_values");
        reset = 1'b0;
        step();
        check_all_zero("idle_after_reset");

        // 1: one full frame streamed at full rate
        enable = 1'b1;
        for (int i = 0; i < 8; i++) push_px(DW'(8'h10 + i));
        run_beats(8, span);
        check("throughput_span", 32'(span), 32'(7));
        step();

        // 2: backpressure while holding 0x22
        for (int i = 0; i < 4; i++) push_px(DW'(8'h20 + i));
        wait_data(8'h22);
        pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_no_pop", 32'(last_ack), 32'(0));
            check("bp_data", 32'({pix_valid, pix_data}), 32'({1'b1, 8'h22}));
        end
        pix_ready = 1'b1;
        run_beats(2, span);

        // 3: FIFO underrun mid-row, then pop alongside a beat
        push_px(8'h24);
        push_px(8'h25);
        run_beats(2, span);
        for (int i = 0; i < 2; i++) begin
            step();
            check("underrun_invalid", 32'(pix_valid), 32'(0));
        end
        push_px(8'h26);
        step();
        check("underrun_resume", 32'({pix_valid, pix_data}), 32'({1'b1, 8'h26}));
        push_px(8'h27);
        step();
        check("pop_with_beat", 32'(last_ack), 32'(1));
        run_beats(1, span);
        step();

        // 4: overflow after three beats, discard, resync on vsync
        for (int i = 0; i < 8; i++) push_px(DW'(8'h30 + i));
        run_beats(3, span);
        exp_q.delete();
        discarding       = 1'b1;
        fifo_overflow_in = 1'b1;
        step();
        check("ovf_no_pop", 32'(last_ack), 32'(0));
        fifo_overflow_in = 1'b0;
        fifo_q.delete();
        check("ovf_drop", 32'(pix_valid), 32'(0));
        check("ovf_err", 32'(err_overflow), 32'(1));
        push_px(8'h40);
        push_px(8'h41);
        push_px(8'h42);
        step();
        check("discard_pops", 32'(last_ack), 32'(1));
        for (int i = 0; i < 4; i++) step();
        check("discard_drained", 32'(fifo_q.size()), 32'(0));
        check("discard_invalid", 32'(pix_valid), 32'(0));
        frame_start_in = 1'b1;
        step();
        frame_start_in = 1'b0;
        discarding     = 1'b0;
        tb_col         = 0;
        tb_row         = 0;
        for (int i = 0; i < 8; i++) push_px(DW'(8'hA0 + i));
        run_beats(8, span);
        step();
        check("err_sticky", 32'(err_overflow), 32'(1));

        // 5: enable dropped mid-frame stops only at the frame boundary
        for (int i = 0; i < 10; i++) push_px(DW'(8'h50 + i));
        wait_data(8'h52);
        enable = 1'b0;
        run_beats(6, span);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("stopped_no_pop", 32'({last_ack, pix_valid}), 32'(0));
        end
        check("stopped_fifo_held", 32'(fifo_q.size()), 32'(2));
        enable = 1'b1;
        run_beats(2, span);

        // 6: reset mid-frame with a held pixel
        push_px(8'h60);
        push_px(8'h61);
        wait_data(8'h60);
        pix_ready = 1'b0;
        step();
        reset     = 1'b1;
        pix_ready = 1'b1;
        step();
        check("reset_no_pop", 32'(last_ack), 32'(0));
        reset = 1'b0;
        check_all_zero("reset_mid_frame");
        exp_q.delete();
        tb_col = 0;
        tb_row = 0;
        tmp    = fifo_q;
        fifo_q.delete();
        foreach (tmp[i]) push_px(tmp[i]);
        run_beats(1, span);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
